// File: rtl/buffer_pkg.sv
// Shared definitions for the register-buffer read side: depth helper, count width and the
// output-stage state encoding.
package buffer_pkg;

   // Output-stage occupancy; the encoding doubles as out_valid.
   typedef enum logic {
      HoldEmpty = 1'b0,
      HoldFull  = 1'b1
   } hold_state_e;

   localparam int unsigned DefBufferWidth = 2;
   // Count must reach DEPTH itself, hence one bit wider than a pointer.
   localparam int unsigned DefCountWidth  = DefBufferWidth + 1;

   function automatic int unsigned buf_depth(input int unsigned width);
      return 32'd1 << width;
   endfunction

   function automatic int unsigned count_width(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/buffer_reader_pointer.sv
// Wrapping buffer pointer: advances by one (mod 2**Width) on each enabled cycle.
module buffer_reader_pointer
   import buffer_pkg::*;
#(
   parameter int unsigned Width = DefBufferWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [Width-1:0] ptr
);

   logic [Width-1:0] ptr_q, ptr_d;

   // Next pointer: natural wrap at the top of the buffer.
   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/buffer_reader.sv
// Read-side controller for the small register buffer: read pointer, occupancy, one-entry
// registered output stage with valid/ready, and full/empty back-pressure status.
// Optional sticky overflow detection is compiled in with BUFFER_READER_OVF_CHECK_EN.
module buffer_reader
   import buffer_pkg::*;
#(
   parameter int unsigned BufferWidth = DefBufferWidth,
   parameter int unsigned DataWidth   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [BufferWidth-1:0] wr_ptr,
   output logic [BufferWidth-1:0] rd_addr,
   input  logic [DataWidth-1:0]   rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DataWidth-1:0]   out_data,
   output logic [BufferWidth:0]   count,
   output logic                   empty,
   output logic                   full,
   output logic                   overflow
);

   localparam int unsigned Depth      = buf_depth(BufferWidth);
   localparam int unsigned CountWidth = count_width(BufferWidth);
   localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);

   hold_state_e            state_q, state_d;
   logic [DataWidth-1:0]   data_q, data_d;
   logic [CountWidth-1:0]  count_q, count_d;
   logic [BufferWidth-1:0] rd_ptr;
   logic                   pop;
   logic                   wr_acc;

   assign empty     = (count_q == '0);
   assign full      = (count_q == DepthCount);
   assign out_valid = (state_q == HoldFull);
   // Pop whenever there is an entry and the output register is free or being drained.
   assign pop       = !empty && (!out_valid || out_ready);
   // A write into a full buffer is a protocol violation and is not counted.
   assign wr_acc    = wr_en && !full;

   buffer_reader_pointer #(
      .Width (BufferWidth)
   ) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .en  (pop),
      .ptr (rd_ptr)
   );

   // Occupancy: +1 per accepted write, -1 per pop, unchanged when both happen.
   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Output stage: load on pop, empty out when consumed with nothing behind it.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
         HoldEmpty: begin
            if (pop) begin
               state_d = HoldFull;
               data_d  = rd_data;
            end
         end
         HoldFull: begin
            if (pop) begin
               data_d = rd_data;
            end else if (out_ready) begin
               state_d = HoldEmpty;
            end
         end
         default: state_d = HoldEmpty;
      endcase
   end

   // State registers for occupancy and the output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HoldEmpty;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign rd_addr  = rd_ptr;
   assign out_data = data_q;
   assign count    = count_q;

`ifdef BUFFER_READER_OVF_CHECK_EN
   logic                   ovf_q, ovf_d;
   logic [BufferWidth-1:0] ptr_diff;
   logic                   ptr_mismatch;

   assign ptr_diff     = wr_ptr - rd_ptr;
   // Pointer distance must always agree with the low bits of the occupancy count.
   assign ptr_mismatch = (ptr_diff != count_q[BufferWidth-1:0]);

   // Sticky overflow: write into a full buffer or write/read pointer disagreement.
   always_comb begin
      ovf_d = ovf_q;
      if ((wr_en && full) || ptr_mismatch) begin
         ovf_d = 1'b1;
      end
   end

   // Overflow flag register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`else
   logic unused_wr_ptr;

   assign unused_wr_ptr = ^wr_ptr;
   assign overflow      = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader: directed scenarios plus randomized traffic, with a
// scoreboard queue of accepted writes consumed by an independent output monitor.
module tb_buffer_reader;

   localparam int unsigned BW    = 2;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [BW-1:0] wr_ptr_tb;
   logic [BW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [BW:0]   count;
   logic          empty;
   logic          full;
   logic          overflow;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;
   logic          ovf_mode = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   buffer_reader #(
      .BufferWidth (BW),
      .DataWidth   (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_ptr    (wr_ptr_tb),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   assign rd_data = mem[rd_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Write side of the buffer plus scoreboard push of every accepted write.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_tb <= '0;
         exp_q.delete();
      end else if (wr_en) begin
         mem[wr_ptr_tb] <= wr_data;
         wr_ptr_tb      <= wr_ptr_tb + 1'b1;
         if (!full) exp_q.push_back(wr_data);
      end
   end

   // Monitor: occupancy/pointer consistency, stall stability and in-order data.
   always @(negedge clk) begin
      int            exp_cnt;
      logic [BW-1:0] exp_addr;
      logic [DW-1:0] exp_d;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         exp_cnt  = int'(exp_q.size()) - int'(out_valid);
         exp_addr = wr_ptr_tb - exp_cnt[BW-1:0];
         check("count", 32'(count), exp_cnt);
         check("empty", 32'(empty), 32'(exp_cnt == 0));
         check("full", 32'(full), 32'(exp_cnt == DEPTH));
         if (!ovf_mode) check("rd_addr", 32'(rd_addr), 32'(exp_addr));
`ifndef BUFFER_READER_OVF_CHECK_EN
         check("overflow_off", 32'(overflow), 32'd0);
`endif
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               exp_d = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(exp_d));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
      wr_en     = w && !full;
      wr_data   = d;
      out_ready = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_addr", 32'(rd_addr), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      wr_en = 1'b0;
      @(negedge clk);
      #1;
      rst      = 1'b0;
      ovf_mode = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      #1;
      do_reset();

      // Single write: valid two edges after the write edge.
      drive(1'b1, 16'hA5A5, 1'b1);
      step();
      drive(1'b0, '0, 1'b1);
      check("t1_valid_n1", 32'(out_valid), 32'd0);
      check("t1_count_n1", 32'(count), 32'd1);
      step();
      check("t1_valid_n2", 32'(out_valid), 32'd1);
      check("t1_data_n2", 32'(out_data), 32'hA5A5);
      check("t1_count_n2", 32'(count), 32'd0);
      step();
      check("t1_drained", 32'(out_valid), 32'd0);

      // Fill with downstream stalled, then drain with wrap of the read pointer.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         step();
      end
      check("t2_count3", 32'(count), 32'd3);
      check("t2_notfull", 32'(full), 32'd0);
      check("t2_head", 32'(out_data), 32'd1);
      drive(1'b1, 16'd5, 1'b0);
      step();
      check("t2_count4", 32'(count), 32'd4);
      check("t2_full", 32'(full), 32'd1);
      drive(1'b0, '0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("t2_drain_valid", 32'(out_valid), 32'd1);
         check("t2_drain_data", 32'(out_data), 32'(k + 1));
         check("t2_drain_count", 32'(count), 32'(4 - k));
      end
      step();
      check("t2_done", 32'(out_valid), 32'd0);

      // Streaming: one entry per cycle, no bubbles.
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, DW'(16'h0100 + i), 1'b1);
         step();
         check("t3_count", 32'(count), 32'd1);
         if (i >= 1) check("t3_nobubble", 32'(out_valid), 32'd1);
      end
      drive(1'b0, '0, 1'b1);
      step();
      check("t3_last_valid", 32'(out_valid), 32'd1);
      check("t3_last_data", 32'(out_data), 32'h010B);
      step();
      check("t3_done", 32'(out_valid), 32'd0);

      // Ready toggled 1,0,0,1 with two entries behind the output register.
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, DW'(16'hC000 + i), 1'b0);
         step();
      end
      check("t4_count2", 32'(count), 32'd2);
      drive(1'b0, '0, 1'b1); step();
      drive(1'b0, '0, 1'b0); step();
      step();
      drive(1'b0, '0, 1'b1); step();
      check("t4_data", 32'(out_data), 32'hC003);
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_count0", 32'(count), 32'd0);
      step();

      // Write into a full buffer: count saturates, overflow only with the check compiled in.
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, DW'(16'hF000 + i), 1'b0);
         step();
      end
      ovf_mode = 1'b1;
      wr_en    = 1'b1;
      wr_data  = 16'hDEAD;
      step();
      wr_en = 1'b0;
      check("t5_count_sat", 32'(count), 32'd4);
`ifdef BUFFER_READER_OVF_CHECK_EN
      check("t5_ovf_set", 32'(overflow), 32'd1);
      step();
      step();
      check("t5_ovf_sticky", 32'(overflow), 32'd1);
`else
      check("t5_ovf_tied", 32'(overflow), 32'd0);
`endif
      check("t5_count_hold", 32'(count), 32'd4);
      do_reset();

      // Reset while an entry is held and two more are buffered.
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, DW'(16'hB000 + i), 1'b0);
         step();
      end
      check("t6_count2", 32'(count), 32'd2);
      check("t6_addr", 32'(rd_addr), 32'd1);
      drive(1'b0, '0, 1'b0);
      #1;
      do_reset();
      drive(1'b1, 16'hBEEF, 1'b1);
      step();
      drive(1'b0, '0, 1'b1);
      step();
      check("t6_first_valid", 32'(out_valid), 32'd1);
      check("t6_first_data", 32'(out_data), 32'hBEEF);
      step();

      // Randomized traffic; the monitor checks everything.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) < 6), DW'($urandom), ($urandom_range(0, 9) < 7));
         step();
      end
      drive(1'b0, '0, 1'b1);
      for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) step();
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
      check("rand_count0", 32'(count), 32'd0);
      check("rand_valid0", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
